flp_norm_pipe: RTL
==================

FLP_NORM_PIPE -- requirements
Module: flp_norm_pipe

Interface
REQ-001 SHALL have parameter INWIDTH, default 32: input significand width.
REQ-002 SHALL have parameter EWIDTH, default 8: exponent width; exponent delta width is EWIDTH+2.
REQ-003 SHALL have parameter SWIDTH, default 23: stored significand width.
REQ-004 SHALL have parameter RSWIDTH, default 2: round/sticky bits; output width OW = 1+SWIDTH+RSWIDTH.
REQ-005 SHALL have parameter HBIT, default 25: input bit index of the hidden bit when exponent delta is zero.
REQ-006 SHALL have parameter TWIDTH, default 4: width of the pass-through tag.
REQ-007 SHALL have port clk  input  1: single clock, rising edge.
REQ-008 SHALL have port nrst  input  1: asynchronous active-low reset.
REQ-009 SHALL have port i_vld  input  1: input beat valid.
REQ-010 SHALL have port o_rdy  output  1: block accepts a beat this cycle.
REQ-011 SHALL have port i_sg  input  INWIDTH: unsigned significand.
REQ-012 SHALL have port i_tag  input  TWIDTH: opaque tag.
REQ-013 SHALL have port o_vld  output  1: output beat valid.
REQ-014 SHALL have port i_rdy  input  1: downstream accepts the output beat.
REQ-015 SHALL have port o_sg  output  OW: normalized significand, MSB is the hidden one.
REQ-016 SHALL have port o_exd  output  EWIDTH+2: two's-complement exponent delta.
REQ-017 SHALL have port o_zero  output  1: input was zero.
REQ-018 SHALL have port o_tag  output  TWIDTH: tag of the output beat.

Function
REQ-019 SHALL transfer a beat on input when i_vld&&o_rdy, and on output when o_vld&&i_rdy, at the rising clk edge.
REQ-020 SHALL implement a two-stage pipeline with per-stage valid; stage k advances when it is empty or the next stage advances; latency 2 cycles with no stall.
REQ-021 SHALL drive o_rdy = !s1_vld || !s2_vld || i_rdy, combinationally; full throughput of 1 beat/cycle.
REQ-022 SHALL in stage 1 register i_sg, i_tag, zero flag (i_sg==0) and leading-one index L from a combinational leading-zero counter.
REQ-023 SHALL in stage 2 right-shift by L-(OW-1) when L>OW-1, ORing all shifted-out bits into o_sg[0] (sticky).
REQ-024 SHALL in stage 2 left-shift by (OW-1)-L when L<=OW-1, zero-filling, with no sticky contribution.
REQ-025 SHALL produce o_exd = L-HBIT, sign-extended to EWIDTH+2 bits.
REQ-026 SHALL on zero input output o_zero=1, o_sg=0, o_exd=0.
REQ-027 SHALL hold o_vld, o_sg, o_exd, o_zero and o_tag stable while o_vld&&!i_rdy.
REQ-028 SHALL never drop or duplicate beats; with i_rdy low, at most 2 beats are buffered, then o_rdy=0.
REQ-029 SHALL preserve beat order; o_tag equals the i_tag accepted with the same beat.
REQ-030 SHALL accept simultaneous input and output transfers when full (o_rdy=1 via i_rdy=1).

Reset
REQ-031 SHALL on nrst low asynchronously clear both stage valids; o_vld=0, o_sg=0, o_exd=0, o_zero=0, o_tag=0.
REQ-032 SHALL discard any in-flight beats when reset is asserted mid-operation; o_rdy=1 after reset release.
REQ-033 SHALL deassert reset synchronously externally; the first transfer is allowed on the first edge after release.

Structure
REQ-034 SHALL place OW, exponent delta width and FP32 default constants in the shared flp definitions header used by the flp blocks.
REQ-035 SHALL instantiate one sub-module, flp_lzc (parametrised INWIDTH leading-one index plus zero flag, combinational).
REQ-036 SHALL contain no other sub-modules; RTL within 120-400 lines.

Verification
REQ-037 SHALL test i_sg=0x0200_0000 -> o_sg=0x200_0000, o_exd=0x000, o_zero=0, two cycles after acceptance.
REQ-038 SHALL test i_sg=0x0800_0000 -> o_sg=0x200_0000, o_exd=0x002; then 0x0800_0001 -> o_sg=0x200_0001 (sticky), o_exd=0x002.
REQ-039 SHALL test i_sg=0x0080_0000 -> o_sg=0x200_0000, o_exd=0x3FE; and i_sg=0 -> o_zero=1, o_sg=0, o_exd=0.
REQ-040 SHALL test back-to-back beats, tags 1..3, with i_rdy=0 -> o_rdy falls after 2 accepted; release i_rdy -> tags 1,2,3 emerge in order, output stable while stalled.
REQ-041 SHALL test nrst pulse with 2 beats in flight -> o_vld=0 immediately, no stale beat after release.
REQ-042 SHALL test 1000 random beats with random i_vld/i_rdy against a reference model -> zero mismatches.

Source files
------------

// File: rtl/flp_norm_pipe_pkg.sv
// rtl/flp_norm_pipe_pkg.sv - shared flp widths, FP32 defaults and width helpers
package flp_norm_pipe_pkg;

   localparam int FP32_INWIDTH = 32;
   localparam int FP32_EWIDTH  = 8;
   localparam int FP32_SWIDTH  = 23;
   localparam int FP32_RSWIDTH = 2;
   localparam int FP32_HBIT    = 25;
   localparam int FP32_TWIDTH  = 4;
   localparam int FP32_OW      = 1 + FP32_SWIDTH + FP32_RSWIDTH;
   localparam int FP32_EXDW    = FP32_EWIDTH + 2;

   function automatic int ow_of(input int swidth, input int rswidth);
      return 1 + swidth + rswidth;
   endfunction

   function automatic int exdw_of(input int ewidth);
      return ewidth + 2;
   endfunction

   function automatic int idxw_of(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/flp_lzc.sv
// rtl/flp_lzc.sv - leading-one index and zero flag of an unsigned word, combinational
module flp_lzc
   import flp_norm_pipe_pkg::*;
#(
   parameter int INWIDTH = FP32_INWIDTH,
   parameter int IDXW    = idxw_of(INWIDTH)
) (
   input  logic [INWIDTH-1:0] sg,
   output logic [IDXW-1:0]    idx,
   output logic               zero
);

   // Ascending scan: the last hit is the most significant set bit.
   always_comb begin
      idx = '0;
      for (int i = 0; i < INWIDTH; i++) begin
         if (sg[i]) idx = IDXW'(i);
      end
   end

   assign zero = (sg == '0);

endmodule

// File: rtl/flp_norm_pipe.sv
// rtl/flp_norm_pipe.sv - two-stage significand normalizer with sticky rounding bit and tag pass-through
module flp_norm_pipe
   import flp_norm_pipe_pkg::*;
#(
   parameter int INWIDTH   = FP32_INWIDTH,
   parameter int EWIDTH    = FP32_EWIDTH,
   parameter int SWIDTH    = FP32_SWIDTH,
   parameter int RSWIDTH   = FP32_RSWIDTH,
   parameter int HBIT      = FP32_HBIT,
   parameter int TWIDTH    = FP32_TWIDTH,
   localparam int OW       = ow_of(SWIDTH, RSWIDTH),
   localparam int EXDW     = exdw_of(EWIDTH)
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic               i_vld,
   output logic               o_rdy,
   input  logic [INWIDTH-1:0] i_sg,
   input  logic [TWIDTH-1:0]  i_tag,
   output logic               o_vld,
   input  logic               i_rdy,
   output logic [OW-1:0]      o_sg,
   output logic [EXDW-1:0]    o_exd,
   output logic               o_zero,
   output logic [TWIDTH-1:0]  o_tag
);

   localparam int IDXW = idxw_of(INWIDTH);
   localparam int MW   = (INWIDTH > OW) ? INWIDTH : OW;
   localparam int SHW  = idxw_of(MW) + 1;
   localparam logic [SHW-1:0]  OW_TOP = SHW'(OW - 1);
   localparam logic [EXDW-1:0] HBIT_X = EXDW'(HBIT);

   logic [IDXW-1:0]    lz_idx;
   logic               lz_zero;

   logic               s1_vld;
   logic [INWIDTH-1:0] s1_sg;
   logic [TWIDTH-1:0]  s1_tag;
   logic               s1_zero;
   logic [IDXW-1:0]    s1_idx;
   logic               s2_adv;

   logic [SHW-1:0]     lead;
   logic [SHW-1:0]     rsh;
   logic [SHW-1:0]     lsh;
   logic [MW-1:0]      ext;
   logic [MW-1:0]      lost_mask;
   logic [OW-1:0]      norm_sg;
   logic [EXDW-1:0]    norm_exd;

   flp_lzc #(.INWIDTH(INWIDTH)) u_lzc (
      .sg   (i_sg),
      .idx  (lz_idx),
      .zero (lz_zero)
   );

   // Stage 1 advances exactly when o_rdy is high, so o_rdy doubles as its enable.
   assign s2_adv = !o_vld || i_rdy;
   assign o_rdy  = !s1_vld || !o_vld || i_rdy;

   // Wide operands shift right with bits beyond the LSB folded into sticky; narrow ones shift left.
   always_comb begin
      lead      = SHW'(s1_idx);
      ext       = MW'(s1_sg);
      rsh       = lead - OW_TOP;
      lsh       = OW_TOP - lead;
      lost_mask = ~({MW{1'b1}} << rsh);
      if (lead > OW_TOP) begin
         norm_sg = OW'(ext >> rsh) | OW'(|(ext & lost_mask));
      end else begin
         norm_sg = OW'(ext << lsh);
      end
      norm_exd = EXDW'(s1_idx) - HBIT_X;
      if (s1_zero) begin
         norm_sg  = '0;
         norm_exd = '0;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         s1_vld  <= 1'b0;
         s1_sg   <= '0;
         s1_tag  <= '0;
         s1_zero <= 1'b0;
         s1_idx  <= '0;
         o_vld   <= 1'b0;
         o_sg    <= '0;
         o_exd   <= '0;
         o_zero  <= 1'b0;
         o_tag   <= '0;
      end else begin
         if (o_rdy) begin
            s1_vld <= i_vld;
            if (i_vld) begin
               s1_sg   <= i_sg;
               s1_tag  <= i_tag;
               s1_zero <= lz_zero;
               s1_idx  <= lz_idx;
            end
         end
         if (s2_adv) begin
            o_vld <= s1_vld;
            if (s1_vld) begin
               o_sg   <= norm_sg;
               o_exd  <= norm_exd;
               o_zero <= s1_zero;
               o_tag  <= s1_tag;
            end
         end
      end
   end

endmodule
